packet_assembler: RTL

PACKET_ASSEMBLER -- requirements
Module: packet_assembler

---
 rtl/packet_assembler_if.sv | 12 +
 rtl/packet_assembler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler_if.sv
// Beat stream interface feeding packet_assembler: data carries {header, payload}.
interface axi_stream_if #(
  parameter int DATA_WIDTH_BYTES = 3
);
  logic                          valid;
  logic                          ready;
  logic                          last;
  logic [DATA_WIDTH_BYTES*8-1:0] data;

  modport slave  (input valid, input data, input last, output ready);
  modport master (output valid, output data, output last, input ready);
endinterface

// File: rtl/packet_assembler.sv
// Multi-channel packet assembler with round-robin packet presentation.
// Optional idle timeout for partial packets: define PACKET_ASSEMBLER_TIMEOUT_EN.
module packet_assembler #(
  parameter int MAX_BEATS          = 4,
  parameter int HEADER_WIDTH_BYTES = 1,
  parameter int DATA_WIDTH_BYTES   = 2,
  parameter int NUM_CHANNELS       = 2,
  parameter int TIMEOUT_CYCLES     = 16,
  localparam int DATA_WIDTH   = DATA_WIDTH_BYTES * 8,
  localparam int HEADER_WIDTH = HEADER_WIDTH_BYTES * 8,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int LEN_W        = $clog2(MAX_BEATS) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  axi_stream_if.slave                          stream_in,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [CH_W-1:0]                      channel_o,
  output logic [LEN_W-1:0]                     length_o,
  output logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] data_o,
  output logic                                 error_o,
  output logic                                 drop_o
);

  localparam int                      IDX_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [LEN_W-1:0]        MAX_LEN    = LEN_W'(MAX_BEATS);
  localparam logic [HEADER_WIDTH-1:0] NUM_CH_HDR = HEADER_WIDTH'(NUM_CHANNELS);
  localparam logic [CH_W-1:0]         LAST_CH    = CH_W'(NUM_CHANNELS - 1);

  typedef logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] beats_t;

  beats_t                  buffer   [NUM_CHANNELS];
  beats_t                  buffer_n [NUM_CHANNELS];
  logic [LEN_W-1:0]        count    [NUM_CHANNELS];
  logic [LEN_W-1:0]        count_n  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] complete;
  logic [NUM_CHANNELS-1:0] complete_n;
  logic [NUM_CHANNELS-1:0] trunc;
  logic [NUM_CHANNELS-1:0] trunc_n;
  logic [CH_W-1:0]         rr_ptr;

  logic [HEADER_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0]   payload;
  logic [CH_W-1:0]         sel;
  logic                    hdr_ok;
  logic                    accept;
  logic                    xfer;
  logic                    drop_n;
  logic                    pick_ok;
  logic [CH_W-1:0]         pick;
  logic [CH_W-1:0]         cand;
  beats_t                  pick_data;

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle   [NUM_CHANNELS];
  logic [TO_W-1:0] idle_n [NUM_CHANNELS];
`endif

  assign header          = stream_in.data[DATA_WIDTH +: HEADER_WIDTH];
  assign payload         = stream_in.data[DATA_WIDTH-1:0];
  assign sel             = header[CH_W-1:0];
  assign hdr_ok          = (header < NUM_CH_HDR);
  // A complete channel stalls only beats addressed to it; unknown channels are always sunk.
  assign stream_in.ready = !(hdr_ok && complete[sel]);
  assign accept          = stream_in.valid && stream_in.ready;
  assign xfer            = valid_o && ready_i;

  always_comb begin
    buffer_n = buffer;
    drop_n   = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (xfer && (channel_o == CH_W'(c))) begin
        count_n[c]    = '0;
        complete_n[c] = 1'b0;
        trunc_n[c]    = 1'b0;
      end else begin
        count_n[c]    = count[c];
        complete_n[c] = complete[c];
        trunc_n[c]    = trunc[c];
      end
    end
    if (accept && hdr_ok) begin
      if (count[sel] < MAX_LEN) begin
        buffer_n[sel][count[sel][IDX_W-1:0]] = payload;
        count_n[sel] = count[sel] + LEN_W'(1);
      end else begin
        trunc_n[sel] = 1'b1;
      end
      complete_n[sel] = stream_in.last;
    end else begin
      drop_n = accept;
    end
`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (accept && hdr_ok && (sel == CH_W'(c))) begin
        idle_n[c] = '0;
      end else if ((count[c] != '0) && !complete[c]) begin
        if (idle[c] == TO_LAST) begin
          idle_n[c]  = '0;
          count_n[c] = '0;
          trunc_n[c] = 1'b0;
          drop_n     = 1'b1;
        end else begin
          idle_n[c] = idle[c] + TO_W'(1);
        end
      end else begin
        idle_n[c] = '0;
      end
    end
`endif
  end

  // Arbitrate on next-cycle completion so a packet can present right after its last beat.
  always_comb begin
    pick_ok = 1'b0;
    pick    = rr_ptr;
    cand    = rr_ptr;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CHANNELS);
      if (!pick_ok && complete_n[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end else begin
        pick_ok = pick_ok;
      end
    end
    for (int b = 0; b < MAX_BEATS; b++) begin
      pick_data[b] = (LEN_W'(b) < count_n[pick]) ? buffer_n[pick][b] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        buffer[c] <= '0;
        count[c]  <= '0;
      end
      complete  <= '0;
      trunc     <= '0;
      rr_ptr    <= LAST_CH;
      valid_o   <= 1'b0;
      channel_o <= '0;
      length_o  <= '0;
      data_o    <= '0;
      error_o   <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      buffer   <= buffer_n;
      count    <= count_n;
      complete <= complete_n;
      trunc    <= trunc_n;
      drop_o   <= drop_n;
      if (!valid_o || ready_i) begin
        valid_o <= pick_ok;
        if (pick_ok) begin
          channel_o <= pick;
          rr_ptr    <= pick;
          length_o  <= count_n[pick];
          data_o    <= pick_data;
          error_o   <= trunc_n[pick];
        end else begin
          channel_o <= '0;
          length_o  <= '0;
          data_o    <= '0;
          error_o   <= 1'b0;
        end
      end
    end
  end

`ifdef PACKET_ASSEMBLER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        idle[c] <= '0;
      end
    end else begin
      idle <= idle_n;
    end
  end
`endif

endmodule
